// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// control register layout and byte-masked write helpers.
package intc_pkg;

    localparam logic [2:0] PENDING   = 3'd0;
    localparam logic [2:0] ENABLE    = 3'd1;
    localparam logic [2:0] CONTROL   = 3'd2;
    localparam logic [2:0] ACTIVE    = 3'd3;
    localparam logic [2:0] PRIORITY  = 3'd4;
    localparam logic [2:0] LAST_ADDR = PRIORITY;

    typedef enum logic {IDLE, REQUEST} intc_state_t;

    typedef struct packed {
        logic global_enable;
    } intc_control_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] strobe);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strobe[b]}};
        return mask;
    endfunction

    function automatic logic [31:0] apply_write(input logic [31:0] old_value,
                                                input logic [31:0] data,
                                                input logic [3:0]  strobe);
        return (old_value & ~byte_mask(strobe)) | (data & byte_mask(strobe));
    endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Combinational winner selection among candidate sources. Lowest index wins;
// with INTC_PRIORITY_EN the highest 2-bit priority wins, ties to lowest index.
module intc_arbiter #(
    parameter int SOURCES  = 8,
    parameter int VECTOR_W = 3
) (
    input  logic [SOURCES-1:0]   candidate_i,
`ifdef INTC_PRIORITY_EN
    input  logic [2*SOURCES-1:0] priority_i,
`endif
    output logic                 valid_o,
    output logic [VECTOR_W-1:0]  index_o
);

`ifdef INTC_PRIORITY_EN
    logic [1:0] best;
`endif

    // Walking downwards with >= lets the lowest index win among equal priorities.
    always_comb begin
        valid_o = |candidate_i;
        index_o = '0;
`ifdef INTC_PRIORITY_EN
        best = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (candidate_i[i] && priority_i[2*i +: 2] >= best) begin
                best    = priority_i[2*i +: 2];
                index_o = VECTOR_W'(i);
            end
        end
`else
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (candidate_i[i]) index_o = VECTOR_W'(i);
        end
`endif
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing interrupt controller with a register interface and a
// request/ack handshake to the CPU. Optional priorities via INTC_PRIORITY_EN.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int SOURCES  = 8,
    parameter int VECTOR_W = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [SOURCES-1:0]  irq_i,
    input  logic                write_i,
    input  logic [31:0]         write_data_i,
    input  logic [2:0]          write_address_i,
    input  logic [3:0]          write_strobe_i,
    output logic                write_error_o,
    input  logic                read_i,
    input  logic [2:0]          read_address_i,
    output logic [31:0]         read_data_o,
    output logic                read_error_o,
    output logic                interrupt_o,
    output logic [VECTOR_W-1:0] interrupt_vector_o,
    input  logic                interrupt_ack_i
);

    logic [SOURCES-1:0]  irq_q, pending_q, pending_d, enable_q, enable_d;
    logic [SOURCES-1:0]  irq_edge, w1c_clr, ack_clr, pending_keep, candidate;
    intc_control_t       control_q, control_d;
    intc_state_t         state_q, state_d;
    logic [VECTOR_W-1:0] vector_q, vector_d, arb_index;
    logic                arb_valid;
`ifdef INTC_PRIORITY_EN
    localparam int PRIO_W = 2 * SOURCES;
    logic [PRIO_W-1:0]   prio_q, prio_d;
`endif

    // NOTE: every variable gets its default before the case so no path infers a latch.
    always_comb begin
        irq_edge  = irq_i & ~irq_q;
        enable_d  = enable_q;
        control_d = control_q;
        w1c_clr   = '0;
`ifdef INTC_PRIORITY_EN
        prio_d    = prio_q;
`endif
        if (write_i) begin
            case (write_address_i)
                PENDING:  w1c_clr  = SOURCES'(write_data_i & byte_mask(write_strobe_i));
                ENABLE:   enable_d = SOURCES'(apply_write(32'(enable_q), write_data_i, write_strobe_i));
                CONTROL:  if (write_strobe_i[0]) control_d.global_enable = write_data_i[0];
`ifdef INTC_PRIORITY_EN
                PRIORITY: prio_d   = PRIO_W'(apply_write(32'(prio_q), write_data_i, write_strobe_i));
`endif
                default: ;
            endcase
        end
        // Pending as it will stand after this edge, ignoring any ack clear.
        pending_keep = (pending_q & ~w1c_clr) | irq_edge;
        candidate    = pending_q & enable_q & {SOURCES{control_q.global_enable}};
    end

    intc_arbiter #(
        .SOURCES  (SOURCES),
        .VECTOR_W (VECTOR_W)
    ) u_arbiter (
        .candidate_i (candidate),
`ifdef INTC_PRIORITY_EN
        .priority_i  (prio_q),
`endif
        .valid_o     (arb_valid),
        .index_o     (arb_index)
    );

    // Withdraw looks at next-cycle register values so a clear drops the request on the same edge.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = REQUEST;
                    vector_d = arb_index;
                end
            end
            REQUEST: begin
                if (interrupt_ack_i) begin
                    state_d           = IDLE;
                    ack_clr[vector_q] = 1'b1;
                end else if (!pending_keep[vector_q] || !enable_d[vector_q] ||
                             !control_d.global_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~(w1c_clr | ack_clr)) | irq_edge;
    end

    // NOTE: flops use non-blocking assignments and all state, including the edge detectors, resets.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            control_q <= '0;
            state_q   <= IDLE;
            vector_q  <= '0;
`ifdef INTC_PRIORITY_EN
            prio_q    <= '0;
`endif
        end else begin
            irq_q     <= irq_i;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            control_q <= control_d;
            state_q   <= state_d;
            vector_q  <= vector_d;
`ifdef INTC_PRIORITY_EN
            prio_q    <= prio_d;
`endif
        end
    end

    always_comb begin
        read_data_o = '0;
        case (read_address_i)
            PENDING:  read_data_o    = 32'(pending_q);
            ENABLE:   read_data_o    = 32'(enable_q);
            CONTROL:  read_data_o[0] = control_q.global_enable;
            ACTIVE:   read_data_o    = {state_q == REQUEST, {(31-VECTOR_W){1'b0}}, vector_q};
`ifdef INTC_PRIORITY_EN
            PRIORITY: read_data_o    = 32'(prio_q);
`endif
            default: ;
        endcase
    end

    assign interrupt_o        = (state_q == REQUEST);
    assign interrupt_vector_o = vector_q;
    assign write_error_o      = write_i & (write_address_i > LAST_ADDR);
    assign read_error_o       = read_i & (read_address_i > LAST_ADDR);

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed steps followed by
// random traffic, compared every cycle against a behavioural model.
module tb_interrupt_controller;
    import intc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = '0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic [2:0]  waddr = '0;
    logic [3:0]  wstrb = '0;
    logic        read = 1'b0;
    logic [2:0]  raddr = '0;
    logic        ack = 1'b0;
    logic        write_error, read_error, interrupt;
    logic [31:0] read_data;
    logic [2:0]  vector;

    always #5 clk = ~clk;

    interrupt_controller #(.SOURCES(8), .VECTOR_W(3)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .irq_i              (irq),
        .write_i            (write),
        .write_data_i       (wdata),
        .write_address_i    (waddr),
        .write_strobe_i     (wstrb),
        .write_error_o      (write_error),
        .read_i             (read),
        .read_address_i     (raddr),
        .read_data_o        (read_data),
        .read_error_o       (read_error),
        .interrupt_o        (interrupt),
        .interrupt_vector_o (vector),
        .interrupt_ack_i    (ack)
    );

    int total = 0, passed = 0, failed = 0, cyc = 0;

    // Behavioural model state.
    logic [7:0]  m_pend, m_en, m_prev;
    logic        m_ge, m_req;
    int          m_vec;
    logic [15:0] m_prio;

`ifdef INTC_PRIORITY_EN
    localparam bit PRIO_ON = 1'b1;
`else
    localparam bit PRIO_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s (cycle %0d): observed 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int prio_of(input int i);
        return PRIO_ON ? int'(m_prio[2*i +: 2]) : 0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] addr);
        case (addr)
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_en);
            3'd2: return 32'(m_ge);
            3'd3: return {m_req, 28'b0, 3'(m_vec)};
            3'd4: return PRIO_ON ? 32'(m_prio) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_prev = '0; m_ge = 1'b0;
        m_req = 1'b0; m_vec = 0; m_prio = '0;
    endtask

    task automatic model_step();
        logic [31:0] mask, t;
        logic [7:0]  edges, w1c, keep, nen, cand;
        logic        nge;
        logic [15:0] nprio;
        int          best, w;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{wstrb[b]}};
        edges = irq & ~m_prev;
        w1c = '0; nen = m_en; nge = m_ge; nprio = m_prio;
        if (write) begin
            case (waddr)
                3'd0: begin t = wdata & mask; w1c = t[7:0]; end
                3'd1: begin t = (32'(m_en) & ~mask) | (wdata & mask); nen = t[7:0]; end
                3'd2: if (wstrb[0]) nge = wdata[0];
                3'd4: if (PRIO_ON) begin t = (32'(m_prio) & ~mask) | (wdata & mask); nprio = t[15:0]; end
                default: ;
            endcase
        end
        keep = (m_pend & ~w1c) | edges;
        if (m_req) begin
            if (ack) begin
                m_req = 1'b0;
                if (!edges[m_vec]) keep[m_vec] = 1'b0;
            end else if (!keep[m_vec] || !nen[m_vec] || !nge) begin
                m_req = 1'b0;
            end
        end else begin
            cand = m_pend & m_en & {8{m_ge}};
            best = -1; w = 0;
            for (int i = 0; i < 8; i++)
                if (cand[i] && prio_of(i) > best) begin best = prio_of(i); w = i; end
            if (best >= 0) begin m_req = 1'b1; m_vec = w; end
        end
        m_pend = keep; m_en = nen; m_ge = nge; m_prio = nprio; m_prev = irq;
    endtask

    task automatic tick();
        logic [31:0] mask;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("interrupt_o", 32'(interrupt), 32'(m_req));
        if (m_req) check("vector", 32'(vector), m_vec);
        mask = (raddr == ACTIVE && !m_req) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFF;
        check("read_data", read_data & mask, exp_read(raddr) & mask);
        check("write_error", 32'(write_error), 32'(write && waddr > 3'd4));
        check("read_error", 32'(read_error), 32'(read && raddr > 3'd4));
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] strb);
        write = 1'b1; waddr = addr; wdata = data; wstrb = strb;
        tick();
        write = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_vector", 32'(vector), 32'h0);
        for (int a = 0; a < 5; a++) begin
            raddr = 3'(a); #1;
            check("rst_read", read_data, 32'h0);
        end
        raddr = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single source, latency and ack.
        wr(ENABLE, 32'h01, 4'hF);
        wr(CONTROL, 32'h01, 4'hF);
        irq = 8'h01; tick(); irq = '0;
        check("t1_no_req_yet", 32'(interrupt), 32'h0);
        tick();
        check("t1_req", 32'(interrupt), 32'h1);
        check("t1_vec", 32'(vector), 32'h0);
        tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        check("t1_ack_drop", 32'(interrupt), 32'h0);
        raddr = PENDING; #1;
        check("t1_pend_clear", read_data, 32'h0);

        // Two simultaneous sources, lowest index first, one idle cycle between.
        wr(ENABLE, 32'hFF, 4'h1);
        irq = 8'h24; tick(); irq = '0; tick();
        check("t2_req", 32'(interrupt), 32'h1);
        check("t2_vec2", 32'(vector), 32'h2);
        ack = 1'b1; tick(); ack = 1'b0;
        check("t2_idle_gap", 32'(interrupt), 32'h0);
        tick();
        check("t2_req5", 32'(interrupt), 32'h1);
        check("t2_vec5", 32'(vector), 32'h5);
        ack = 1'b1; tick(); ack = 1'b0; tick();

        // Withdraw by software clearing the pending bit.
        irq = 8'h08; tick(); irq = '0; tick();
        check("t3_vec3", 32'(vector), 32'h3);
        wr(PENDING, 32'h08, 4'hF);
        check("t3_withdraw", 32'(interrupt), 32'h0);
        tick();
        check("t3_stay_idle", 32'(interrupt), 32'h0);

        // New edge coinciding with the ack keeps the source pending.
        irq = 8'h02; tick(); irq = '0; tick();
        check("t4_vec1", 32'(vector), 32'h1);
        ack = 1'b1; irq = 8'h02; tick(); ack = 1'b0; irq = '0;
        check("t4_ack_drop", 32'(interrupt), 32'h0);
        raddr = PENDING; #1;
        check("t4_pend_kept", read_data, 32'h02);
        tick();
        check("t4_rereq", 32'(interrupt), 32'h1);
        check("t4_revec", 32'(vector), 32'h1);
        ack = 1'b1; tick(); ack = 1'b0; tick();

        // Priority register: source 2 at level 3.
        wr(PRIORITY, 32'h30, 4'hF);
        raddr = PRIORITY; #1;
        check("t5_prio_read", read_data, PRIO_ON ? 32'h30 : 32'h0);
        irq = 8'h05; tick(); irq = '0; tick();
        check("t5_req", 32'(interrupt), 32'h1);
        check("t5_vec", 32'(vector), PRIO_ON ? 32'h2 : 32'h0);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        check("t5_vec_second", 32'(vector), PRIO_ON ? 32'h0 : 32'h2);
        ack = 1'b1; tick(); ack = 1'b0;
        wr(PRIORITY, 32'h0, 4'hF);

        // Ack while idle is ignored.
        ack = 1'b1; tick(); ack = 1'b0;
        check("t6_idle_ack", 32'(interrupt), 32'h0);

        // Asynchronous reset in the middle of a request.
        irq = 8'h01; tick(); irq = '0; tick();
        check("t7_req", 32'(interrupt), 32'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t7_rst_interrupt", 32'(interrupt), 32'h0);
        raddr = PENDING; #1;
        check("t7_rst_pending", read_data, 32'h0);
        raddr = ENABLE; #1;
        check("t7_rst_enable", read_data, 32'h0);
        write = 1'b1; waddr = 3'd6; #1;
        check("t7_write_error", 32'(write_error), 32'h1);
        read = 1'b1; raddr = 3'd5; #1;
        check("t7_read_error", 32'(read_error), 32'h1);
        write = 1'b0; read = 1'b0; raddr = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic against the model.
        wr(ENABLE, $urandom, 4'hF);
        wr(CONTROL, 32'h1, 4'h1);
        for (int n = 0; n < 800; n++) begin
            irq   = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h0;
            write = ($urandom_range(0, 5) == 0);
            waddr = 3'($urandom_range(0, 7));
            wdata = $urandom;
            if (waddr == CONTROL) wdata[0] = ($urandom_range(0, 3) != 0);
            wstrb = 4'($urandom_range(0, 15));
            ack   = interrupt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            read  = ($urandom_range(0, 1) == 0);
            raddr = 3'($urandom_range(0, 7));
            tick();
        end
        irq = '0; write = 1'b0; read = 1'b0; ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
